// File: rtl/switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer_pkg
// Description : Shared constants and types for the slide-switch debouncer.
//               Holds the board switch width, the clock rate, the debounce
//               window, and the per-bit debounce state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_debouncer_pkg;

    localparam int SW_WIDTH        = 6;
    localparam int CLK_HZ          = 50000000;
    localparam int DEBOUNCE_MS     = 20;
    localparam int DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    // Per-bit debounce state: waiting for a difference, or timing one.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

endpackage : switch_debouncer_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : Single-bit switch conditioner. It uses a two-flop
//               synchroniser and a stability counter, and produces one-cycle
//               rise/fall pulses on each accepted change.
// Ports       : clk      - rising-edge clock
//               rst      - asynchronous active-high reset
//               i_sw     - raw asynchronous switch input
//               o_stable - debounced value (registered)
//               o_rise   - one-cycle pulse on accepted 0->1
//               o_fall   - one-cycle pulse on accepted 1->0
//               o_accept - combinational: a change is accepted on this edge
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_rise;
    logic             r_fall;
    db_state_t        r_state;

    logic             w_differ;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stable_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    db_state_t        w_state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_state  <= ST_IDLE;
        end else begin
            r_sync1  <= i_sw;
            r_sync2  <= r_sync1;
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_state  <= w_state_nxt;
        end
    end

    assign w_differ = (r_sync2 != r_stable);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_accept     = 1'b0;

        case (r_state)
            // Counter is held at zero here, so the first differing edge
            // counts as cycle one of the window (or accepts at once when the
            // window is a single cycle).
            ST_IDLE: begin
                if (w_differ) begin
                    if (r_cnt == c_last) begin
                        w_accept = 1'b1;
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_state_nxt = ST_COUNTING;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            // Any bounce back to the old value restarts the window fully.
            ST_COUNTING: begin
                if (!w_differ) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == c_last) begin
                    w_accept = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_stable_nxt = r_sync2;
            w_cnt_nxt    = '0;
            w_state_nxt  = ST_IDLE;
            w_rise_nxt   = r_sync2;
            w_fall_nxt   = ~r_sync2;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Conditions the raw slide-switch bus before it reaches the
//               display/LED logic. Each bit is synchronised into CLOCK_50
//               and debounced independently. The block emits the clean vector,
//               per-bit rise/fall pulses, and a summary change flag.
// Ports       : CLOCK_50   - system clock, rising edge
//               reset      - asynchronous active-high reset
//               SW         - raw bouncing switches [0:WIDTH-1]
//               sw_stable  - debounced switch vector
//               sw_rise    - per-bit one-cycle 0->1 pulse
//               sw_fall    - per-bit one-cycle 1->0 pulse
//               sw_changed - registered OR of all rise/fall pulses
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [0:WIDTH-1] SW,
    output logic [0:WIDTH-1] sw_stable,
    output logic [0:WIDTH-1] sw_rise,
    output logic [0:WIDTH-1] sw_fall,
    output logic             sw_changed
);

    logic [0:WIDTH-1] w_accept;
    logic             r_changed;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_debounce_bit (
            .clk      (CLOCK_50),
            .rst      (reset),
            .i_sw     (SW[gi]),
            .o_stable (sw_stable[gi]),
            .o_rise   (sw_rise[gi]),
            .o_fall   (sw_fall[gi]),
            .o_accept (w_accept[gi])
        );
    end

    // Registered from the same acceptance terms that load the pulse flops,
    // so the flag lines up with the pulses rather than lagging by a cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_accept;
        end
    end

    assign sw_changed = r_changed;

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Self-checking bench for switch_debouncer. It exercises a
//               4-cycle window build and a 1-cycle window build. Expected
//               output snapshots are queued as stimulus is driven and checked
//               when their due cycle arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    logic       clk;
    logic       rst;
    logic [0:5] sw_a;
    logic [0:5] sw_b;

    logic [0:5] a_stable, a_rise, a_fall;
    logic       a_chg;
    logic [0:5] b_stable, b_rise, b_fall;
    logic       b_chg;

    switch_debouncer #(.WIDTH(6), .STABLE_CYCLES(4)) dut_a (
        .CLOCK_50   (clk),
        .reset      (rst),
        .SW         (sw_a),
        .sw_stable  (a_stable),
        .sw_rise    (a_rise),
        .sw_fall    (a_fall),
        .sw_changed (a_chg)
    );

    switch_debouncer #(.WIDTH(6), .STABLE_CYCLES(1)) dut_b (
        .CLOCK_50   (clk),
        .reset      (rst),
        .SW         (sw_b),
        .sw_stable  (b_stable),
        .sw_rise    (b_rise),
        .sw_fall    (b_fall),
        .sw_changed (b_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         unit;
        string      tag;
        logic [0:5] st;
        logic [0:5] ri;
        logic [0:5] fa;
        logic       ch;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp;
    int   n_fail;
    int   cyc;

    function automatic logic [0:5] oh(int i);
        logic [0:5] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic cmp(string tag, logic [0:5] obs, logic [0:5] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_out(int unit, int dly, string tag,
                              logic [0:5] st, logic [0:5] ri,
                              logic [0:5] fa, logic ch);
        exp_t e;
        e.due  = cyc + dly;
        e.unit = unit;
        e.tag  = tag;
        e.st   = st;
        e.ri   = ri;
        e.fa   = fa;
        e.ch   = ch;
        sbq.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due <= cyc) begin
                exp_t e;
                e = sbq[i];
                if (e.unit == 0) begin
                    cmp({e.tag, ".stable"}, a_stable, e.st);
                    cmp({e.tag, ".rise"},   a_rise,   e.ri);
                    cmp({e.tag, ".fall"},   a_fall,   e.fa);
                    cmp({e.tag, ".chg"},    {5'b0, a_chg}, {5'b0, e.ch});
                end else begin
                    cmp({e.tag, ".stable"}, b_stable, e.st);
                    cmp({e.tag, ".rise"},   b_rise,   e.ri);
                    cmp({e.tag, ".fall"},   b_fall,   e.fa);
                    cmp({e.tag, ".chg"},    {5'b0, b_chg}, {5'b0, e.ch});
                end
                sbq.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        rst    = 1'b1;
        sw_a   = '0;
        sw_b   = '0;

        // Reset state
        tick();
        tick();
        expect_out(0, 0, "reset_a", '0, '0, '0, 1'b0);
        expect_out(1, 0, "reset_b", '0, '0, '0, 1'b0);
        check_due();

        // Quiet inputs after release: nothing may move
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            expect_out(0, k, "idle_a", '0, '0, '0, 1'b0);
            expect_out(1, k, "idle_b", '0, '0, '0, 1'b0);
        end
        repeat (20) tick();

        // Clean rise on bit 2: accepted 5 edges after sampling
        sw_a[2] = 1'b1;
        expect_out(0, 5, "rise2_pre", '0,    '0,    '0, 1'b0);
        expect_out(0, 6, "rise2",     oh(2), oh(2), '0, 1'b1);
        expect_out(0, 7, "rise2_end", oh(2), '0,    '0, 1'b0);
        repeat (8) tick();

        // Clean fall on bit 2
        sw_a[2] = 1'b0;
        expect_out(0, 5, "fall2_pre", oh(2), '0, '0,    1'b0);
        expect_out(0, 6, "fall2",     '0,    '0, oh(2), 1'b1);
        expect_out(0, 7, "fall2_end", '0,    '0, '0,    1'b0);
        repeat (8) tick();

        // Bouncing bit 2: no acceptance until 5 edges after the last 0->1
        for (int k = 1; k <= 9; k++)
            expect_out(0, k, "bounce_hold", '0, '0, '0, 1'b0);
        expect_out(0, 10, "bounce_rise", oh(2), oh(2), '0, 1'b1);
        expect_out(0, 11, "bounce_end",  oh(2), '0,    '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            sw_a[2] = (k % 2 == 0);
            tick();
        end
        repeat (7) tick();

        // Bring bit 0 high
        sw_a[0] = 1'b1;
        expect_out(0, 6, "rise0", oh(0) | oh(2), oh(0), '0, 1'b1);
        repeat (8) tick();

        // Simultaneous fall on bit 0 and rise on bit 5
        sw_a[0] = 1'b0;
        sw_a[5] = 1'b1;
        expect_out(0, 6, "pair",     oh(2) | oh(5), oh(5), oh(0), 1'b1);
        expect_out(0, 7, "pair_end", oh(2) | oh(5), '0,    '0,    1'b0);
        repeat (8) tick();

        // Bit 3 rises, reset hits mid-count between edges (counter = 2)
        sw_a[3] = 1'b1;
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        expect_out(0, 0, "async_rst_a", '0, '0, '0, 1'b0);
        expect_out(1, 0, "async_rst_b", '0, '0, '0, 1'b0);
        check_due();
        tick();
        tick();
        // Released with switches held: full latency incl. synchroniser
        rst = 1'b0;
        expect_out(0, 5, "post_rst_pre", '0, '0, '0, 1'b0);
        expect_out(0, 6, "post_rst",
                   oh(2) | oh(3) | oh(5), oh(2) | oh(3) | oh(5), '0, 1'b1);
        expect_out(0, 7, "post_rst_end", oh(2) | oh(3) | oh(5), '0, '0, 1'b0);
        repeat (8) tick();

        // Single-cycle window build: 2-edge latency after sampling
        sw_b[1] = 1'b1;
        expect_out(1, 2, "s1_pre",  '0,    '0,    '0, 1'b0);
        expect_out(1, 3, "s1_rise", oh(1), oh(1), '0, 1'b1);
        expect_out(1, 4, "s1_end",  oh(1), '0,    '0, 1'b0);
        repeat (5) tick();
        sw_b[1] = 1'b0;
        expect_out(1, 2, "s1_fall_pre", oh(1), '0, '0,    1'b0);
        expect_out(1, 3, "s1_fall",     '0,    '0, oh(1), 1'b1);
        repeat (5) tick();

        // Every queued expectation must have been consumed
        cmp("sb_drain", 6'(sbq.size()), 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire
